// File: rtl/key_fifo_pkg.sv
// Purpose : constants and helpers shared by the keyboard character FIFO and the decoder.
// Latency : n/a (package only).
// Backpr. : n/a.
//
// Contents: KEY_WIDTH / KEY_DEPTH defaults, key_log2() sizing helper,
//           ASCII control characters the decoder emits.
package key_fifo_pkg;

   localparam int KEY_WIDTH = 8;
   localparam int KEY_DEPTH = 16;

   localparam logic [7:0] KEY_BS = 8'h08;   // backspace
   localparam logic [7:0] KEY_NL = 8'h0A;   // newline

   // Ceiling log2, used only for elaboration-time sizing.
   function automatic int key_log2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/key_fifo_mem.sv
// Purpose : DEPTH x WIDTH character storage for key_char_fifo.
// Latency : write lands at the clock edge; read port is combinational from raddr.
// Backpr. : none; the caller qualifies we.
//
// Ports: clk; we/waddr/wdata write port; raddr/rdata asynchronous read port.
// Contents are deliberately not reset: the FIFO gates rd_data with its empty flag.
module key_fifo_mem
   import key_fifo_pkg::*;
#(
   parameter int WIDTH = KEY_WIDTH,
   parameter int DEPTH = KEY_DEPTH,
   localparam int AW   = key_log2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/key_char_fifo.sv
// Purpose : first-word-fall-through FIFO buffering keyboard characters for the processor port.
// Latency : push visible on rd_data/flags one cycle later; pop advances rd_data one cycle later.
// Backpr. : no ready to the decoder; a push while full (without pop) is dropped and flagged.
//
// Ports: clk, reset_n (async, active low); push/push_data from the decoder; pop from the
//        processor port; clear = synchronous flush overriding push/pop; rd_data (0 when empty),
//        empty, full, count (0..DEPTH), sticky overflow.
// Build option: define KEY_FIFO_DROP_CNT_EN to add drop_cnt[7:0], a saturating count of
//        dropped pushes, cleared by reset and clear.
module key_char_fifo
   import key_fifo_pkg::*;
#(
   parameter int WIDTH = KEY_WIDTH,
   parameter int DEPTH = KEY_DEPTH,
   localparam int PTR_W = key_log2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             clear,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full,
   output logic [PTR_W:0]   count,
`ifdef KEY_FIFO_DROP_CNT_EN
   output logic [7:0]       drop_cnt,
`endif
   output logic             overflow
);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PTR_W:0]   wr_ptr, rd_ptr;
   logic [PTR_W:0]   wr_ptr_nxt, rd_ptr_nxt;
   logic             push_ok, pop_ok, drop;
   logic [WIDTH-1:0] mem_rdata;

   // A pop frees a slot in the same edge, so push while full is fine if pop is present.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop);
   assign drop    = push && full && !pop;

   always_comb begin
      wr_ptr_nxt = wr_ptr + {{PTR_W{1'b0}}, push_ok};
      rd_ptr_nxt = rd_ptr + {{PTR_W{1'b0}}, pop_ok};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         empty    <= 1'b1;
         full     <= 1'b0;
         overflow <= 1'b0;
      end else if (clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         empty    <= 1'b1;
         full     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
         // Modular pointer difference is exact over 0..DEPTH thanks to the wrap bit.
         count  <= wr_ptr_nxt - rd_ptr_nxt;
         empty  <= (wr_ptr_nxt == rd_ptr_nxt);
         full   <= (wr_ptr_nxt[PTR_W] != rd_ptr_nxt[PTR_W]) &&
                   (wr_ptr_nxt[PTR_W-1:0] == rd_ptr_nxt[PTR_W-1:0]);
         if (drop) overflow <= 1'b1;
      end
   end

`ifdef KEY_FIFO_DROP_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drop_cnt <= '0;
      end else if (clear) begin
         drop_cnt <= '0;
      end else if (drop && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end
`endif

   key_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push_ok && !clear),
      .waddr (wr_ptr[PTR_W-1:0]),
      .wdata (push_data),
      .raddr (rd_ptr[PTR_W-1:0]),
      .rdata (mem_rdata)
   );

   // Storage is unreset, so the empty gate keeps rd_data at zero when nothing is held.
   assign rd_data = empty ? '0 : mem_rdata;

endmodule

// File: tb/tb_key_char_fifo.sv
// Purpose : self-checking bench for key_char_fifo.
// Latency : stimulus drives after each rising edge; checks sample #1 after the edge or at negedge.
// Backpr. : n/a.
//
// Stimulus queues the characters it expects to be read; a monitor compares rd_data against
// that queue whenever an accepted pop is presented. Status outputs are checked inline.
module tb_key_char_fifo;
   import key_fifo_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       push;
   logic [7:0] push_data;
   logic       pop;
   logic       clear;
   logic [7:0] rd_data;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overflow;
`ifdef KEY_FIFO_DROP_CNT_EN
   logic [7:0] drop_cnt;
`endif

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   key_char_fifo dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .clear     (clear),
      .rd_data   (rd_data),
      .empty     (empty),
      .full      (full),
      .count     (count),
`ifdef KEY_FIFO_DROP_CNT_EN
      .drop_cnt  (drop_cnt),
`endif
      .overflow  (overflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; inputs return to idle just after the edge.
   task automatic cyc(input logic p, input logic [7:0] d, input logic o, input logic c);
      push      = p;
      push_data = d;
      pop       = o;
      clear     = c;
      @(posedge clk);
      #1;
      push  = 1'b0;
      pop   = 1'b0;
      clear = 1'b0;
   endtask

   task automatic push_char(input logic [7:0] d, input bit accepted);
      if (accepted) exp_q.push_back(d);
      cyc(1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic pop_char();
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   // Monitor: an accepted pop means rd_data must be the oldest queued character.
   always @(negedge clk) begin
      if (reset_n && pop && !clear && !empty) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL pop_data: got 0x%0h with no character expected", rd_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (rd_data !== e) begin
               failures++;
               $display("FAIL pop_data: got 0x%0h expected 0x%0h at %0t", rd_data, e, $time);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n   = 1'b0;
      push      = 1'b0;
      push_data = 8'h00;
      pop       = 1'b0;
      clear     = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: reset state
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_count", count, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_overflow", overflow, 0);
`ifdef KEY_FIFO_DROP_CNT_EN
      check("rst_drop_cnt", drop_cnt, 0);
`endif

      // 2: A, B, C then drain
      push_char(8'h41, 1);
      push_char(8'h42, 1);
      push_char(8'h43, 1);
      check("abc_count", count, 3);
      check("abc_head", rd_data, 8'h41);
      repeat (3) pop_char();
      check("abc_empty", empty, 1);
      check("abc_rd_zero", rd_data, 0);
      check("abc_count0", count, 0);

      // 3: fill to full, then one dropped push
      for (int i = 0; i < 16; i++) push_char(8'h60 + 8'(i), 1);
      check("fill_full", full, 1);
      check("fill_count", count, 16);
      check("fill_ovf0", overflow, 0);
      push_char(8'hEE, 0);
      check("drop_ovf", overflow, 1);
      check("drop_count", count, 16);
      check("drop_full", full, 1);
`ifdef KEY_FIFO_DROP_CNT_EN
      check("drop_cnt1", drop_cnt, 1);
      for (int i = 0; i < 300; i++) push_char(8'hEE, 0);
      check("drop_cnt_sat", drop_cnt, 255);
`endif

      // flush, which must also clear the sticky flag
      exp_q.delete();
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      check("clr_count", count, 0);
      check("clr_empty", empty, 1);
      check("clr_ovf", overflow, 0);
      check("clr_full", full, 0);
`ifdef KEY_FIFO_DROP_CNT_EN
      check("clr_drop_cnt", drop_cnt, 0);
`endif

      // 4: refill, then 20 cycles of push+pop while full (wraps the pointers)
      for (int i = 0; i < 16; i++) push_char(8'h10 + 8'(i), 1);
      check("refill_full", full, 1);
      for (int i = 0; i < 20; i++) begin
         exp_q.push_back(8'h80 + 8'(i));
         cyc(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0);
         check("pp_full", full, 1);
         check("pp_ovf", overflow, 0);
         check("pp_count", count, 16);
      end
      repeat (16) pop_char();
      check("pp_drain_empty", empty, 1);

      // 5: push+pop on empty keeps the push; lone pop on empty is ignored
      exp_q.push_back(8'h5A);
      cyc(1'b1, 8'h5A, 1'b1, 1'b0);
      check("pe_count", count, 1);
      check("pe_rd", rd_data, 8'h5A);
      pop_char();
      check("pe_drained", empty, 1);
      pop_char();
      check("pope_count", count, 0);
      check("pope_empty", empty, 1);
      check("pope_ovf", overflow, 0);
      check("pope_rd", rd_data, 0);
      push_char(8'h33, 1);
      check("pope_after_rd", rd_data, 8'h33);
      check("pope_after_cnt", count, 1);
      pop_char();

      // 6: count=5 with overflow set, then clear with a concurrent push
      for (int i = 0; i < 16; i++) push_char(8'hA0 + 8'(i), 1);
      push_char(8'hEF, 0);
      repeat (11) pop_char();
      check("c5_count", count, 5);
      check("c5_ovf", overflow, 1);
      check("c5_rd", rd_data, 8'hAB);
      exp_q.delete();
      cyc(1'b1, 8'h77, 1'b0, 1'b1);
      check("clrp_count", count, 0);
      check("clrp_empty", empty, 1);
      check("clrp_ovf", overflow, 0);
      check("clrp_rd", rd_data, 0);

      // async reset in the middle of a push cycle
      push_char(8'h21, 1);
      push_char(8'h22, 1);
      check("pre_rst_count", count, 2);
      push      = 1'b1;
      push_data = 8'h23;
      #2 reset_n = 1'b0;
      #1;
      exp_q.delete();
      check("arst_count", count, 0);
      check("arst_empty", empty, 1);
      check("arst_full", full, 0);
      check("arst_rd", rd_data, 0);
      check("arst_ovf", overflow, 0);
      @(posedge clk);
      #1;
      check("arst_hold_count", count, 0);
      push = 1'b0;
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("final_empty", empty, 1);
      check("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
